pattern_sender: RTL and testbench

PATTERN_SENDER -- requirements
Module: pattern_sender

---
 rtl/pattern_sender_pkg.sv | 24 ++
 rtl/rx_state_model.sv | 25 ++
 rtl/pattern_sender.sv | 88 ++++++++
 tb/tb_pattern_sender.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sender_pkg.sv
// Shared encodings for the pattern sender and the receiving Moore FSM.
package pattern_sender_pkg;

  localparam int PAT_W = 16;

  // Receiver encodings are fixed by the receiving FSM and must not be reordered.
  typedef enum logic [1:0] {
    RX_B = 2'b00,
    RX_C = 2'b01,
    RX_D = 2'b10,
    RX_A = 2'b11
  } rx_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } ctrl_state_t;

  function automatic logic [4:0] clamp_length(input logic [4:0] len);
    return (len > 5'd16) ? 5'd16 : len;
  endfunction

endpackage

// File: rtl/rx_state_model.sv
// Next-state function of the receiving Moore FSM; its output is 1 only in state A.
module rx_state_model
  import pattern_sender_pkg::*;
(
  input  rx_state_t state,
  input  logic      serial_bit,
  output rx_state_t next_state,
  output logic      enter_a
);

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = RX_B;
    case (state)
      RX_A:    next_state = serial_bit ? RX_C : RX_D;
      RX_B:    next_state = serial_bit ? RX_A : RX_D;
      RX_C:    next_state = serial_bit ? RX_B : RX_C;
      RX_D:    next_state = serial_bit ? RX_B : RX_A;
      default: next_state = RX_B;
    endcase
  end

  assign enter_a = (next_state == RX_A);

endmodule

// File: rtl/pattern_sender.sv
// Serialises up to 16 pattern bits MSB-first and predicts how often the receiver enters A.
module pattern_sender
  import pattern_sender_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pattern,
  input  logic [4:0]  length,
  output logic        serial_out,
  output logic        bit_valid,
  output logic        busy,
  output logic        done,
  output logic [4:0]  hit_count
);

  ctrl_state_t       state;
  rx_state_t         rx_state;
  rx_state_t         rx_next;
  logic              enter_a;
  logic [PAT_W-1:0]  shift_reg;
  logic [4:0]        bit_cnt;
  logic [4:0]        eff_len;
  logic [PAT_W-1:0]  aligned;

  assign eff_len = clamp_length(length);
  assign aligned = pattern << (5'd16 - eff_len);

  // The model steps on the bit currently on the wire, so it tracks the receiver exactly.
  rx_state_model u_rx_state_model (
    .state      (rx_state),
    .serial_bit (serial_out),
    .next_state (rx_next),
    .enter_a    (enter_a)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      rx_state   <= RX_B;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hit_count  <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register updates from pre-edge values.
      case (state)
        ST_IDLE: begin
          if (start && length != 5'd0) begin
            // First bit goes straight to the output; the rest wait in shift_reg.
            serial_out <= aligned[PAT_W-1];
            shift_reg  <= aligned << 1;
            bit_cnt    <= eff_len - 5'd1;
            bit_valid  <= 1'b1;
            busy       <= 1'b1;
            hit_count  <= '0;
            rx_state   <= RX_B;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          rx_state  <= rx_next;
          hit_count <= hit_count + {4'd0, enter_a};
          if (bit_cnt == 5'd0) begin
            serial_out <= 1'b0;
            bit_valid  <= 1'b0;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else begin
            serial_out <= shift_reg[PAT_W-1];
            shift_reg  <= shift_reg << 1;
            bit_cnt    <= bit_cnt - 5'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sender.sv
// Self-checking bench: directed vectors, corner sequences and random transactions vs a model.
module tb_pattern_sender;
  import pattern_sender_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  length = '0;
  logic        serial_out;
  logic        bit_valid;
  logic        busy;
  logic        done;
  logic [4:0]  hit_count;

  int n_checks = 0;
  int n_errors = 0;

  pattern_sender dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .length     (length),
    .serial_out (serial_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .hit_count  (hit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  len;
    logic [15:0] pat;
    int          exp_bits;
    logic [15:0] exp_stream;
    int          exp_hit;
  } vec_t;

  vec_t vecs [5];

  // Receiver transition table, written straight from the state list.
  rx_state_t nxt_tbl [4][2];

  int          obs_bits, obs_first, obs_busy, obs_done_cnt, obs_done_cyc, obs_noise;
  logic [15:0] obs_stream;
  logic [4:0]  obs_hit;
  int          last_exp_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [15:0] pat, input logic [4:0] len,
                                output int nbits, output logic [15:0] stream, output int hits);
    rx_state_t st = RX_B;
    rx_state_t nx;
    int b;
    nbits  = (len > 5'd16) ? 16 : int'(len);
    stream = '0;
    hits   = 0;
    for (int i = 0; i < nbits; i++) begin
      b      = int'(pat[nbits-1-i]);
      stream = {stream[14:0], pat[nbits-1-i]};
      nx     = nxt_tbl[int'(st)][b];
      if (nx == RX_A) hits++;
      st = nx;
    end
  endfunction

  // Launches one transaction and records what the outputs did, sampling on falling edges.
  task automatic run_txn(input logic [15:0] pat, input logic [4:0] len,
                         input int restart_at, input int reset_at);
    @(negedge clock);
    pattern = pat;
    length  = len;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    pattern = 16'($urandom);
    length  = 5'($urandom);
    obs_bits = 0; obs_first = 0; obs_busy = 0; obs_done_cnt = 0; obs_done_cyc = 0;
    obs_noise = 0; obs_stream = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bit_valid) begin
        obs_bits++;
        obs_stream = {obs_stream[14:0], serial_out};
        if (obs_first == 0) obs_first = cyc;
      end else if (serial_out) begin
        obs_noise++;
      end
      if (busy) obs_busy++;
      if (done) begin
        obs_done_cnt++;
        obs_done_cyc = cyc;
        if (bit_valid) obs_noise++;
      end
      obs_hit = hit_count;
      if (!busy) break;
      if (cyc == reset_at) reset = 1'b1;
      if (cyc == restart_at) begin
        start   = 1'b1;
        length  = 5'd5;
        pattern = 16'hFFFF;
      end
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic check_txn(input string name, input logic [15:0] pat, input logic [4:0] len,
                           input int restart_at);
    int          nbits, hits;
    logic [15:0] stream;
    model(pat, len, nbits, stream, hits);
    run_txn(pat, len, restart_at, 0);
    check({name, " bits"},       obs_bits,     nbits);
    check({name, " stream"},     obs_stream,   stream);
    check({name, " first_bit"},  obs_first,    1);
    check({name, " busy_cyc"},   obs_busy,     nbits + 1);
    check({name, " done_cnt"},   obs_done_cnt, 1);
    check({name, " done_cyc"},   obs_done_cyc, nbits + 1);
    check({name, " idle_noise"}, obs_noise,    0);
    check({name, " hit"},        obs_hit,      hits);
    last_exp_hit = hits;
  endtask

  initial begin
    nxt_tbl[int'(RX_A)][1] = RX_C; nxt_tbl[int'(RX_A)][0] = RX_D;
    nxt_tbl[int'(RX_B)][1] = RX_A; nxt_tbl[int'(RX_B)][0] = RX_D;
    nxt_tbl[int'(RX_C)][1] = RX_B; nxt_tbl[int'(RX_C)][0] = RX_C;
    nxt_tbl[int'(RX_D)][1] = RX_B; nxt_tbl[int'(RX_D)][0] = RX_A;

    vecs[0] = '{len: 5'd1,  pat: 16'h0001, exp_bits: 1,  exp_stream: 16'h0001, exp_hit: 1};
    vecs[1] = '{len: 5'd3,  pat: 16'h0007, exp_bits: 3,  exp_stream: 16'h0007, exp_hit: 1};
    vecs[2] = '{len: 5'd4,  pat: 16'h0000, exp_bits: 4,  exp_stream: 16'h0000, exp_hit: 2};
    vecs[3] = '{len: 5'd20, pat: 16'hA5A5, exp_bits: 16, exp_stream: 16'hA5A5, exp_hit: 4};
    vecs[4] = '{len: 5'd16, pat: 16'hFFFF, exp_bits: 16, exp_stream: 16'hFFFF, exp_hit: 6};

    repeat (2) @(negedge clock);
    check("rst busy",       busy,       1'b0);
    check("rst done",       done,       1'b0);
    check("rst bit_valid",  bit_valid,  1'b0);
    check("rst serial_out", serial_out, 1'b0);
    check("rst hit_count",  hit_count,  5'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle busy", busy, 1'b0);

    // Directed table: expectations written by hand from the receiver table.
    foreach (vecs[i]) begin
      run_txn(vecs[i].pat, vecs[i].len, 0, 0);
      check($sformatf("vec%0d bits", i),     obs_bits,     vecs[i].exp_bits);
      check($sformatf("vec%0d stream", i),   obs_stream,   vecs[i].exp_stream);
      check($sformatf("vec%0d first", i),    obs_first,    1);
      check($sformatf("vec%0d busy", i),     obs_busy,     vecs[i].exp_bits + 1);
      check($sformatf("vec%0d done_cnt", i), obs_done_cnt, 1);
      check($sformatf("vec%0d done_cyc", i), obs_done_cyc, vecs[i].exp_bits + 1);
      check($sformatf("vec%0d noise", i),    obs_noise,    0);
      check($sformatf("vec%0d hit", i),      obs_hit,      vecs[i].exp_hit);
      last_exp_hit = vecs[i].exp_hit;
    end

    // Start with length 0 in IDLE: nothing happens and hit_count is retained.
    @(negedge clock);
    pattern = 16'hFFFF;
    length  = 5'd0;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("len0 busy c%0d", k),  busy,      1'b0);
      check($sformatf("len0 valid c%0d", k), bit_valid, 1'b0);
      check($sformatf("len0 hit c%0d", k),   hit_count, 5'(last_exp_hit));
      @(negedge clock);
    end

    // Start pulsed mid-SEND is ignored.
    check_txn("midstart", 16'h0F3C, 5'd12, 4);

    // Reset on the third SEND cycle aborts without a done pulse.
    run_txn(16'hBEEF, 5'd16, 0, 3);
    check("abort bits",     obs_bits,     3);
    check("abort done_cnt", obs_done_cnt, 0);
    check("abort busy",     busy,         1'b0);
    check("abort hit",      hit_count,    5'd0);
    check("abort valid",    bit_valid,    1'b0);
    check_txn("post_abort", 16'h0007, 5'd3, 0);

    for (int r = 0; r < 20; r++) begin
      logic [4:0]  rl;
      logic [15:0] rp;
      rl = 5'($urandom_range(1, 31));
      rp = 16'($urandom);
      check_txn($sformatf("rnd%0d", r), rp, rl, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
